// File: rtl/sar_logic_pkg.sv
// Shared constants and state encoding for the SAR conversion controller.
// The divider and the controller both take their resolution from here.
package sar_logic_pkg;

  localparam int SAR_N_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CONV   = 2'd2,
    ST_HOLD   = 2'd3
  } sar_state_t;

  // Bit-index counter width; stays at least 1 bit so that N=1 still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sar_logic_edge_det.sv
// Registers the sample clock and produces single-edge start / sample-entry pulses.
// cks_q resets to "not sampling", so a reset released mid-phase cannot fake a start.
module sar_edge_det #(
  parameter bit CKS_HIGH_IS_SAMPLE = 1'b1
) (
  input  logic CK,
  input  logic RSTN,
  input  logic CKS,
  output logic cks_lvl,
  output logic start,
  output logic sample_entry
);

  logic cks_q;

  assign cks_lvl = CKS_HIGH_IS_SAMPLE ? CKS : ~CKS;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) cks_q <= 1'b0;
    else       cks_q <= cks_lvl;
  end

  assign start        = ~cks_lvl & cks_q;
  assign sample_entry = cks_lvl & ~cks_q;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: drives the cap-DAC switches MSB first and
// publishes the finished code on D with a one-cycle DONE pulse.
//
// state  | meaning
// IDLE   | disabled or just out of reset, DAC switches cleared
// SAMPLE | input tracking, waiting for the sample clock to drop
// CONV   | one bit decided per CK, idx points at the bit on trial
// HOLD   | result published, waiting for the next sample phase
module sar_logic
  import sar_logic_pkg::*;
#(
  parameter int N                  = SAR_N_DEFAULT,
  parameter bit CKS_HIGH_IS_SAMPLE = 1'b1
) (
  input  logic         CK,
  input  logic         RSTN,
  input  logic         EN,
  input  logic         CKS,
  input  logic         COMP,
  output logic [N-1:0] B,
  output logic [N-1:0] D,
  output logic         DONE,
  output logic         BUSY,
  output logic         OVR
);

  localparam int IW = idx_width(N);

  sar_state_t      state;
  logic [IW-1:0]   idx;
  logic            cks_lvl;
  logic            start;
  logic            sample_entry;

  sar_edge_det #(.CKS_HIGH_IS_SAMPLE(CKS_HIGH_IS_SAMPLE)) u_edge_det (
    .CK          (CK),
    .RSTN        (RSTN),
    .CKS         (CKS),
    .cks_lvl     (cks_lvl),
    .start       (start),
    .sample_entry(sample_entry)
  );

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      B     <= '0;
      D     <= '0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
      OVR   <= 1'b0;
      idx   <= '0;
    end else if (!EN) begin
      state <= ST_IDLE;
      B     <= '0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      OVR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          B     <= '0;
          BUSY  <= 1'b0;
          // Never convert straight out of IDLE; a start needs a SAMPLE state first.
          state <= cks_lvl ? ST_SAMPLE : ST_HOLD;
        end
        ST_SAMPLE: begin
          B <= '0;
          if (start) begin
            B        <= '0;
            B[N-1]   <= 1'b1;
            idx      <= IW'(N - 1);
            BUSY     <= 1'b1;
            state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (sample_entry) begin
            B     <= '0;
            BUSY  <= 1'b0;
            OVR   <= 1'b1;
            state <= ST_SAMPLE;
          end else begin
            B[idx] <= COMP;
            if (idx != '0) begin
              B[idx - 1'b1] <= 1'b1;
              idx           <= idx - 1'b1;
            end else begin
              D     <= {B[N-1:1], COMP};
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (sample_entry) begin
            B     <= '0;
            state <= ST_SAMPLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sar_logic.md
SAR_LOGIC -- requirements
Module: sar_logic

Interface
REQ-001 Parameter: N, default 10, resolution in bits (DAC control and result width).
REQ-002 Parameter: CKS_HIGH_IS_SAMPLE, default 1, sampling phase is CKS=1; conversion phase is CKS=0.
REQ-003 Port: CK  input  1  conversion clock, rising-edge active, same clock that drives the sample-clock divider.
REQ-004 Port: RSTN  input  1  asynchronous active-low reset.
REQ-005 Port: EN  input  1  block enable; low forces idle.
REQ-006 Port: CKS  input  1  sample-phase clock from the divider, synchronous to CK; no synchronizer required.
REQ-007 Port: COMP  input  1  comparator decision; 1 = Vin above DAC level, keep the trial bit.
REQ-008 Port: B  output  N  capacitive-DAC switch controls, MSB first; registered.
REQ-009 Port: D  output  N  last completed conversion result; registered, held between conversions.
REQ-010 Port: DONE  output  1  one-CK pulse when D is updated.
REQ-011 Port: BUSY  output  1  high while in CONV.
REQ-012 Port: OVR  output  1  one-CK pulse when a conversion is aborted by CKS returning to sample phase.

Function
REQ-013 The block SHALL register CKS into cks_q every CK edge and detect start as (CKS==0 && cks_q==1), and sample entry as (CKS==1 && cks_q==0).
REQ-014 States: IDLE, SAMPLE, CONV, HOLD; encoding is free, with one-hot or binary allowed.
REQ-015 IDLE: B=0, BUSY=0; when EN=1 go to SAMPLE if CKS=1, else HOLD.
REQ-016 SAMPLE: B=0; on start edge go to CONV, set B={1,0..0}, set idx=N-1, and set BUSY=1.
REQ-017 CONV, each edge: B[idx]<=COMP; if idx>0, set B[idx-1]<=1 and idx<=idx-1.
REQ-018 CONV with idx==0: D<={B[N-1:1],COMP}, DONE<=1, BUSY<=0, state HOLD; B keeps the final code.
REQ-019 Latency: DONE SHALL assert on the (N+1)th CK edge after the start edge, which is edge 11 for N=10; this fits in the 13-cycle conversion phase.
REQ-020 HOLD: on sample-entry edge, set B<=0 and go to SAMPLE.
REQ-021 Sample-entry edge while in CONV: abort, keep D unchanged, pulse OVR, set B<=0, BUSY<=0, state SAMPLE.
REQ-022 Start edge while in CONV or HOLD is impossible without an intervening sample entry and SHALL be ignored.
REQ-023 A start edge seen in IDLE is ignored; the first conversion begins only after a full SAMPLE phase.
REQ-024 EN=0 on any edge SHALL synchronously force IDLE, B=0, BUSY=0, DONE=0, OVR=0, with D retained; this takes priority over all other events.
REQ-025 The idx counter is ceil(log2(N)) bits wide and SHALL never underflow; it is reloaded only at start.
REQ-026 DONE and OVR SHALL never assert on the same edge.

Reset
REQ-027 RSTN low SHALL asynchronously set state=IDLE, B=0, D=0, DONE=0, BUSY=0, OVR=0, idx=0, cks_q=0.
REQ-028 Reset deassertion mid-phase SHALL not create a spurious start; cks_q=0 after reset guarantees that.
REQ-029 Reset asserted mid-conversion SHALL discard the partial code; D reads 0.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the default N, so the divider and top-level share the resolution constant.
REQ-031 One sub-module is natural, sar_edge_det, which handles CKS registration and the start/sample-entry pulse generation; everything else stays flat.

Verification
REQ-032 Directed scenario: the bench SHALL drive CKS from the real divider with EN=1 and model COMP as (Vin_code >= B), Vin_code=10'h2A5 -> D=10'h2A5 and DONE at edge 11 after the CKS fall.
REQ-033 Directed scenario: COMP held 1 -> B walks 200,300,380...3FF and D=10'h3FF; COMP held 0 -> D=10'h000 and B ends 000.
REQ-034 Directed scenario: CKS forced high 5 edges after start -> OVR pulse for exactly one cycle, D retains the previous value, and B=0.
REQ-035 Directed scenario: EN dropped at conversion step 4 -> next edge IDLE, B=0, BUSY=0, no DONE; EN re-raised during CKS=0 -> no conversion until the next sample phase.
REQ-036 Directed scenario: RSTN pulsed low asynchronously between edges in CONV -> outputs zero immediately, and no DONE within the following 26 CKs unless a full sample phase occurs.
REQ-037 Directed scenario: a 1000-conversion random Vin_code sweep -> every D matches the model, and DONE count equals the count of CKS falling edges preceded by a full sample phase.
